// File: rtl/aes_prng_entropy_responder.sv
// Entropy responder for the AES masking PRNG: packs upstream beats into words,
// drops repeated words, buffers them and serves one word per req/ack.
module aes_prng_entropy_responder #(
  parameter int SrcWidth     = 16,
  parameter int EntropyWidth = 32,
  parameter int Depth        = 2,
  localparam int LvlW        = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    src_valid_i,
  output logic                    src_ready_o,
  input  logic [SrcWidth-1:0]     src_data_i,
  input  logic                    entropy_req_i,
  output logic                    entropy_ack_o,
  output logic [EntropyWidth-1:0] entropy_o,
  output logic [LvlW-1:0]         level_o,
  output logic                    rep_err_o
);

  localparam int R    = EntropyWidth / SrcWidth;
  localparam int CntW = (R > 1) ? $clog2(R) : 1;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [EntropyWidth-1:0] pack_q, pack_d;
  logic [EntropyWidth-1:0] mem_q [Depth];
  logic [EntropyWidth-1:0] mem_d [Depth];
  logic [LvlW-1:0]         level_q, level_d;
  logic [EntropyWidth-1:0] last_q, last_d;
  logic                    last_vld_q, last_vld_d;
  logic                    rep_err_q, rep_err_d;

  logic                    full, last_beat, beat_xfer, word_done, is_rep, push;
  logic [EntropyWidth-1:0] word;
  logic [LvlW-1:0]         lvl_popped;

  always_comb begin
    full      = (level_q == LvlW'(Depth));
    last_beat = (cnt_q == CntW'(R - 1));

    // Ready looks only at registered state, so a same-cycle pop cannot raise it.
    src_ready_o   = flush_i | ~(last_beat & full);
    beat_xfer     = src_valid_i & src_ready_o;
    entropy_ack_o = entropy_req_i & (level_q != '0) & ~flush_i;
    entropy_o     = entropy_ack_o ? mem_q[0] : '0;
    level_o       = level_q;
    rep_err_o     = rep_err_q;

    word = pack_q;
    for (int k = 0; k < R; k++) begin
      if (cnt_q == CntW'(k)) word[k*SrcWidth +: SrcWidth] = src_data_i;
    end

    word_done = beat_xfer & last_beat & ~flush_i;
    is_rep    = last_vld_q & (word == last_q);
    push      = word_done & ~is_rep;

    cnt_d      = cnt_q;
    pack_d     = pack_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    rep_err_d  = rep_err_q | (word_done & is_rep);
    mem_d      = mem_q;
    lvl_popped = level_q - LvlW'(entropy_ack_o);
    level_d    = level_q;

    if (flush_i) begin
      cnt_d      = '0;
      pack_d     = '0;
      level_d    = '0;
      last_vld_d = 1'b0;
    end else begin
      if (beat_xfer) begin
        cnt_d  = last_beat ? '0 : cnt_q + CntW'(1);
        pack_d = last_beat ? '0 : word;
      end
      if (push) begin
        last_d     = word;
        last_vld_d = 1'b1;
      end
      // Head lives in entry 0; a pop shifts everything down one slot.
      if (entropy_ack_o) begin
        for (int i = 0; i < Depth - 1; i++) mem_d[i] = mem_q[i+1];
      end
      for (int i = 0; i < Depth; i++) begin
        if (push && lvl_popped == LvlW'(i)) mem_d[i] = word;
      end
      level_d = lvl_popped + LvlW'(push);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      pack_q     <= '0;
      level_q    <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      rep_err_q  <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pack_q     <= pack_d;
      level_q    <= level_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      rep_err_q  <= rep_err_d;
      for (int i = 0; i < Depth; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_aes_prng_entropy_responder.sv
// Bench for aes_prng_entropy_responder: directed scenarios then random traffic,
// every cycle compared with a queue-based model of the responder.
module tb_aes_prng_entropy_responder;

  localparam int SW = 16;
  localparam int EW = 32;
  localparam int DEPTH = 2;
  localparam int R = EW / SW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, flush_i = 1'b0, src_valid_i = 1'b0, entropy_req_i = 1'b0;
  logic [SW-1:0] src_data_i = '0;
  logic          src_ready_o, entropy_ack_o, rep_err_o;
  logic [EW-1:0] entropy_o;
  logic [1:0]    level_o;

  aes_prng_entropy_responder #(.SrcWidth(SW), .EntropyWidth(EW), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
    .entropy_req_i(entropy_req_i), .entropy_ack_o(entropy_ack_o), .entropy_o(entropy_o),
    .level_o(level_o), .rep_err_o(rep_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [EW-1:0] m_q[$];
  int            m_cnt;
  logic [EW-1:0] m_part;
  bit            m_lv;
  logic [EW-1:0] m_last;
  bit            m_rerr;

  // Last observed outputs, for scenario-specific checks
  logic          obs_ack, obs_ready;
  logic [EW-1:0] obs_data;

  function automatic void model_reset();
    m_q.delete();
    m_cnt = 0; m_part = '0; m_lv = 0; m_last = '0; m_rerr = 0;
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [SW-1:0] d, input bit rq, input bit fl, input bit rs);
    bit            e_ready, e_ack;
    logic [EW-1:0] e_data, w;
    @(negedge clk);
    src_valid_i = v; src_data_i = d; entropy_req_i = rq; flush_i = fl; rst_i = rs;
    #1;
    e_ready = fl || !(m_cnt == R - 1 && m_q.size() == DEPTH);
    e_ack   = rq && (m_q.size() != 0) && !fl;
    e_data  = e_ack ? m_q[0] : '0;
    chk("src_ready", EW'(src_ready_o), EW'(e_ready));
    chk("ack", EW'(entropy_ack_o), EW'(e_ack));
    chk("entropy", entropy_o, e_data);
    chk("level", EW'(level_o), EW'(m_q.size()));
    chk("rep_err", EW'(rep_err_o), EW'(m_rerr));
    obs_ack = entropy_ack_o; obs_ready = src_ready_o; obs_data = entropy_o;
    @(posedge clk);
    if (rs) model_reset();
    else if (fl) begin
      m_q.delete(); m_cnt = 0; m_part = '0; m_lv = 0;
    end else begin
      if (e_ack) void'(m_q.pop_front());
      if (v && e_ready) begin
        m_part[m_cnt*SW +: SW] = d;
        if (m_cnt == R - 1) begin
          w = m_part;
          if (m_lv && w == m_last) m_rerr = 1;
          else begin
            m_q.push_back(w); m_last = w; m_lv = 1;
          end
          m_cnt = 0; m_part = '0;
        end else m_cnt++;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 16'h0, 0, 0, 0);
    chk("rst_ready", EW'(obs_ready), 32'd1);

    // Basic pack/serve
    step(1, 16'h1111, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("basic_word", obs_data, 32'h2222_1111);
    step(0, 16'h0, 1, 0, 0);
    chk("basic_noack", EW'(obs_ack), 32'd0);

    // Back-to-back serve
    step(1, 16'h0001, 0, 0, 0);
    step(1, 16'hAAAA, 0, 0, 0);
    step(1, 16'h0002, 0, 0, 0);
    step(1, 16'hBBBB, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("b2b_w0", obs_data, 32'hAAAA_0001);
    step(0, 16'h0, 1, 0, 0);
    chk("b2b_w1", obs_data, 32'hBBBB_0002);
    step(0, 16'h0, 1, 0, 0);
    chk("b2b_noack", EW'(obs_ack), 32'd0);

    // Backpressure
    step(1, 16'h0003, 0, 0, 0);
    step(1, 16'hCCCC, 0, 0, 0);
    step(1, 16'h0004, 0, 0, 0);
    step(1, 16'hDDDD, 0, 0, 0);
    step(1, 16'h0005, 0, 0, 0);
    step(1, 16'hEEEE, 0, 0, 0);
    chk("bp_stall", EW'(obs_ready), 32'd0);
    step(1, 16'hEEEE, 0, 0, 0);
    step(1, 16'hEEEE, 1, 0, 0);
    chk("bp_no_popthru", EW'(obs_ready), 32'd0);
    step(1, 16'hEEEE, 0, 0, 0);
    chk("bp_resume", EW'(obs_ready), 32'd1);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("bp_word", obs_data, 32'hEEEE_0005);

    // Repetition
    step(1, 16'h5555, 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    step(1, 16'h5555, 0, 0, 0);
    step(1, 16'h6666, 0, 0, 0);
    step(1, 16'h6666, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    chk("rep_err_set", EW'(rep_err_o), 32'd1);
    chk("rep_level", EW'(level_o), 32'd2);
    step(0, 16'h0, 1, 0, 0);
    chk("rep_w0", obs_data, 32'h5555_5555);
    step(0, 16'h0, 1, 0, 0);
    chk("rep_w1", obs_data, 32'h6666_6666);

    // Flush mid-word
    step(1, 16'h1234, 0, 0, 0);
    step(1, 16'h7777, 0, 0, 0);
    step(1, 16'h1234, 0, 0, 0);
    step(0, 16'h0, 1, 1, 0);
    chk("flush_noack", EW'(obs_ack), 32'd0);
    step(1, 16'hCDEF, 0, 0, 0);
    step(1, 16'h89AB, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("flush_word", obs_data, 32'h89AB_CDEF);
    chk("flush_rep_sticky", EW'(rep_err_o), 32'd1);

    // Reset mid-operation
    step(1, 16'h0007, 0, 0, 0);
    step(1, 16'h0008, 0, 0, 0);
    step(1, 16'h0009, 1, 0, 1);
    step(0, 16'h0, 1, 0, 0);
    chk("rst_mid_ack", EW'(obs_ack), 32'd0);
    chk("rst_mid_rerr", EW'(rep_err_o), 32'd0);
    step(1, 16'h000A, 1, 0, 0);
    step(1, 16'h000B, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("rst_mid_resume", obs_data, 32'h000B_000A);

    // Random traffic from a small data alphabet so repeats occur
    for (int n = 0; n < 600; n++) begin
      logic [SW-1:0] d;
      d = 16'h3C00 + 16'($urandom_range(0, 2));
      step(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 40) == 0), bit'($urandom_range(0, 150) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
